// File: rtl/reset_req_ctrl.sv
// reset_req_ctrl
//   Single-clock reset request controller. Software and watchdog requests
//   start a stretched active-low reset towards downstream per-domain reset
//   synchronizers. The controller then waits for the synchronized reset level
//   that comes back from the downstream domain, and it reports the reset
//   cause, a busy flag and a sticky timeout error.
//
//   Optional feature (macro RST_REQ_PEND_EN): a request that arrives while busy
//   is remembered, with WDT winning over SW. It is replayed one cycle after the
//   controller returns to IDLE. When the macro is undefined, such requests are
//   dropped.
//
// Parameters
//   STRETCH_CYC  minimum low width of RST_OUT_N in cycles (2 .. 2^CNT_W-1)
//   ACK_TIMEOUT  maximum cycles spent in any ack-wait      (1 .. 2^CNT_W-1)
//   CNT_W        width of the shared stretch/timeout counter
//
// Ports
//   CLK          system clock
//   RST          asynchronous active-high reset (forces a power-on sequence)
//   SW_RST_REQ   software reset request, level
//   WDT_EXP      watchdog expiry request, level
//   RST_ACK      downstream synchronized reset level, asynchronous to CLK
//   ERR_CLR      single-cycle clear of TIMEOUT_ERR
//   RST_OUT_N    registered active-low reset to downstream synchronizers
//   BUSY         high whenever the controller is not IDLE
//   RST_CAUSE    cause of last reset: 00 none, 01 SW, 10 WDT, 11 POR
//   TIMEOUT_ERR  sticky ack-wait timeout flag
module reset_req_ctrl #(
    parameter int STRETCH_CYC = 16,
    parameter int ACK_TIMEOUT = 200,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW_RST_REQ,
    input  logic       WDT_EXP,
    input  logic       RST_ACK,
    input  logic       ERR_CLR,
    output logic       RST_OUT_N,
    output logic       BUSY,
    output logic [1:0] RST_CAUSE,
    output logic       TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;
    localparam logic [1:0] CAUSE_POR = 2'b11;

    localparam int CNT_MAX_I     = (1 << CNT_W) - 1;
    localparam int STRETCH_LAST  = STRETCH_CYC - 1;
    // The counter saturates, so an abort point beyond its range is clamped to
    // the saturation value to keep the stuck-ack abort reachable.
    localparam int ASSERT_LIMIT  = (STRETCH_CYC - 1 + ACK_TIMEOUT > CNT_MAX_I) ?
                                   CNT_MAX_I : (STRETCH_CYC - 1 + ACK_TIMEOUT);
    localparam int RELEASE_LIMIT = ACK_TIMEOUT - 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       cause_q, cause_d;
    logic             err_q, err_set;
    logic             out_n_q, busy_q;
    logic             ack_p0, ack_s;

`ifdef RST_REQ_PEND_EN
    logic             pend_q, pend_d;
    logic [1:0]       pend_cause_q, pend_cause_d;
`endif

    // Stage p0/s: two-flop synchronizer for the asynchronous downstream ack
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_p0 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_p0 <= RST_ACK;
            ack_s  <= ack_p0;
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        err_set = 1'b0;
`ifdef RST_REQ_PEND_EN
        pend_d       = pend_q;
        pend_cause_d = pend_cause_q;
`endif
        case (state_q)
            IDLE: begin
                if (WDT_EXP) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    cause_d = CAUSE_WDT;
                end
`ifdef RST_REQ_PEND_EN
                else if (pend_q) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    cause_d = pend_cause_q;
                end
`endif
                else if (SW_RST_REQ) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    cause_d = CAUSE_SW;
                end
`ifdef RST_REQ_PEND_EN
                // Whatever was pending has just been served.
                if (state_d == ASSERT) begin
                    pend_d = 1'b0;
                end
`endif
            end
            ASSERT: begin
                if ((int'(cnt_q) >= STRETCH_LAST) && !ack_s) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (int'(cnt_q) >= ASSERT_LIMIT) begin
                    // The downstream domain never entered reset; give up waiting.
                    err_set = 1'b1;
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (ack_s) begin
                    state_d = IDLE;
                end else if (int'(cnt_q) >= RELEASE_LIMIT) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
`ifdef RST_REQ_PEND_EN
        // Capture requests that arrive while busy. A WDT overwrites a pending SW.
        // A SW never downgrades a pending WDT.
        if (state_q != IDLE) begin
            if (WDT_EXP) begin
                pend_d       = 1'b1;
                pend_cause_d = CAUSE_WDT;
            end else if (SW_RST_REQ) begin
                pend_d = 1'b1;
                if (!(pend_q && (pend_cause_q == CAUSE_WDT))) begin
                    pend_cause_d = CAUSE_SW;
                end
            end
        end
`endif
    end

    // State, counter and registered outputs. Outputs are computed from the
    // next state, so they change on the same edge as the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            cause_q <= CAUSE_POR;
            err_q   <= 1'b0;
            out_n_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            // A set wins over a coincident clear.
            err_q   <= err_set | (err_q & ~ERR_CLR);
            out_n_q <= (state_d != ASSERT);
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef RST_REQ_PEND_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q       <= 1'b0;
            pend_cause_q <= 2'b00;
        end else begin
            pend_q       <= pend_d;
            pend_cause_q <= pend_cause_d;
        end
    end
`endif

    assign RST_OUT_N   = out_n_q;
    assign BUSY        = busy_q;
    assign RST_CAUSE   = cause_q;
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_reset_req_ctrl.sv
// Directed testbench for reset_req_ctrl (default parameters). It covers
// power-on, SW and WDT requests, ack-stuck timeout, requests while busy and
// reset asserted mid-sequence. Expectations for RST_REQ_PEND_EN follow the macro.
module tb_reset_req_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SW_RST_REQ;
    logic       WDT_EXP;
    logic       RST_ACK;
    logic       ERR_CLR;
    logic       RST_OUT_N;
    logic       BUSY;
    logic [1:0] RST_CAUSE;
    logic       TIMEOUT_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    reset_req_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .SW_RST_REQ  (SW_RST_REQ),
        .WDT_EXP     (WDT_EXP),
        .RST_ACK     (RST_ACK),
        .ERR_CLR     (ERR_CLR),
        .RST_OUT_N   (RST_OUT_N),
        .BUSY        (BUSY),
        .RST_CAUSE   (RST_CAUSE),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges until RST_OUT_N is high. The ack drops at tick drop_at and
    // WDT_EXP pulses at tick wdt_at; 0 disables either.
    task automatic wait_rise(input int drop_at, input int wdt_at, output int n);
        n = 9999;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (RST_OUT_N === 1'b1) begin
                n = i;
                break;
            end
            if (i == drop_at) RST_ACK = 1'b0;
            WDT_EXP = (i == wdt_at);
        end
        WDT_EXP = 1'b0;
    endtask

    // Optionally raises the ack 3 cycles after entry, then counts edges from
    // that point until BUSY is low.
    task automatic wait_idle(input bit raise_ack, output int n);
        if (raise_ack) begin
            repeat (3) tick();
            RST_ACK = 1'b1;
        end
        n = 9999;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (BUSY === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic quiet_check(input string tag);
        bit seen = 1'b0;
        repeat (12) begin
            tick();
            if (BUSY !== 1'b0 || RST_OUT_N !== 1'b1) seen = 1'b1;
        end
        check_eq(tag, int'(seen), 0);
    endtask

    int n;

    initial begin
        RST = 1'b1; SW_RST_REQ = 1'b0; WDT_EXP = 1'b0; RST_ACK = 1'b0; ERR_CLR = 1'b0;

        // Power-on reset
        repeat (5) tick();
        check_eq("por_out_n",  int'(RST_OUT_N), 0);
        check_eq("por_busy",   int'(BUSY), 1);
        check_eq("por_cause",  int'(RST_CAUSE), 3);
        check_eq("por_err",    int'(TIMEOUT_ERR), 0);
        RST = 1'b0;
        wait_rise(0, 0, n);
        check_eq("por_stretch", n, 16);
        check_eq("por_busy_after_rise", int'(BUSY), 1);
        wait_idle(1'b1, n);
        check_eq("por_busy_fall", n, 3);
        check_eq("por_cause_kept", int'(RST_CAUSE), 3);
        check_eq("por_err_after", int'(TIMEOUT_ERR), 0);

        // Software request, single-cycle pulse
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        check_eq("sw_out_n_fall", int'(RST_OUT_N), 0);
        check_eq("sw_cause", int'(RST_CAUSE), 1);
        check_eq("sw_busy", int'(BUSY), 1);
        wait_rise(3, 0, n);
        check_eq("sw_stretch", n, 16);
        wait_idle(1'b1, n);
        check_eq("sw_busy_fall", n, 3);

        // Simultaneous SW and WDT: WDT wins, one sequence only
        SW_RST_REQ = 1'b1; WDT_EXP = 1'b1;
        tick();
        SW_RST_REQ = 1'b0; WDT_EXP = 1'b0;
        check_eq("both_out_n_fall", int'(RST_OUT_N), 0);
        check_eq("both_cause", int'(RST_CAUSE), 2);
        wait_rise(3, 0, n);
        check_eq("both_stretch", n, 16);
        wait_idle(1'b1, n);
        check_eq("both_busy_fall", n, 3);
        quiet_check("both_single_seq");

        // Ack stuck at 1: stretch plus timeout, then release completes at once
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        check_eq("stuck_err_before", int'(TIMEOUT_ERR), 0);
        wait_rise(0, 0, n);
        check_eq("stuck_stretch", n, 216);
        check_eq("stuck_err_set", int'(TIMEOUT_ERR), 1);
        wait_idle(1'b0, n);
        check_eq("stuck_release", n, 1);

        // WDT pulse while busy; the error must survive the new request
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        check_eq("busy_cause_sw", int'(RST_CAUSE), 1);
        wait_rise(3, 4, n);
        check_eq("busy_stretch", n, 16);
        check_eq("busy_cause_kept", int'(RST_CAUSE), 1);
        wait_idle(1'b1, n);
        check_eq("busy_busy_fall", n, 3);
`ifdef RST_REQ_PEND_EN
        tick();
        check_eq("pend_busy", int'(BUSY), 1);
        check_eq("pend_out_n", int'(RST_OUT_N), 0);
        check_eq("pend_cause", int'(RST_CAUSE), 2);
        wait_rise(3, 0, n);
        check_eq("pend_stretch", n, 16);
        wait_idle(1'b1, n);
        check_eq("pend_busy_fall", n, 3);
`else
        quiet_check("busy_dropped");
        check_eq("busy_cause_final", int'(RST_CAUSE), 1);
`endif
        check_eq("err_sticky", int'(TIMEOUT_ERR), 1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check_eq("err_cleared", int'(TIMEOUT_ERR), 0);

        // RST asserted mid-RELEASE
        SW_RST_REQ = 1'b1;
        tick();
        SW_RST_REQ = 1'b0;
        wait_rise(3, 0, n);
        check_eq("mid_stretch", n, 16);
        check_eq("mid_in_release", int'(BUSY), 1);
        #2;
        RST = 1'b1;
        #1;
        check_eq("mid_async_out_n", int'(RST_OUT_N), 0);
        check_eq("mid_cause_por", int'(RST_CAUSE), 3);
        check_eq("mid_busy", int'(BUSY), 1);
        repeat (2) tick();
        RST = 1'b0;
        wait_rise(0, 0, n);
        check_eq("mid_restretch", n, 16);
        wait_idle(1'b1, n);
        check_eq("mid_busy_fall", n, 3);
        check_eq("mid_err", int'(TIMEOUT_ERR), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
